sine_rom_sequencer: RTL and testbench

Phase-accumulator controller for the sine-sample ROM. On each sample-rate tick it advances a phase accumulator and issues one synchronous ROM read at the accumulator's top address bits. It re-times the returned word into a registered sample with a valid strobe and a period-start marker. It sits between the sample-rate timing generator and the downstream DAC/serializer, and is the only master of the ROM's `en`/`address` pins.

---
 rtl/sine_rom_sequencer.sv | 110 +++++++++++
 tb/tb_sine_rom_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_rom_sequencer.sv
// sine_rom_sequencer: phase-accumulator read sequencer for a synchronous sine ROM
module sine_rom_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int PHASE_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [PHASE_W-1:0]       step,
  input  logic                     tick,
  output logic                     rom_en,
  output logic [$clog2(DEPTH)-1:0] rom_addr,
  input  logic [WIDTH-1:0]         rom_data,
  output logic [WIDTH-1:0]         sample,
  output logic                     sample_valid,
  output logic                     wrap,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state_q, state_d;
  logic [PHASE_W-1:0] step_q, step_d, phase_q, phase_d;
  logic [PHASE_W:0] sum_w;
  logic wpend_q, wpend_d;
  logic rom_en_q, rom_en_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic iss_w_q, iss_w_d, ret_v_q, ret_v_d, ret_w_q, ret_w_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic sample_valid_q, sample_valid_d, wrap_q, wrap_d, busy_q, busy_d;
  assign sum_w = {1'b0, phase_q} + {1'b0, step_q};
  // Next-state: control FSM, phase advance on tick, and the issue/return tag pipeline (rom_en_q is the issue-stage valid)
  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    phase_d        = phase_q;
    wpend_d        = wpend_q;
    rom_en_d       = 1'b0;
    rom_addr_d     = rom_addr_q;
    iss_w_d        = iss_w_q;
    ret_v_d        = rom_en_q;
    ret_w_d        = iss_w_q;
    sample_d       = ret_v_q ? rom_data : sample_q;
    sample_valid_d = ret_v_q;
    wrap_d         = ret_v_q & ret_w_q;
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d = RUN;
        step_d  = step;
        phase_d = '0;
        wpend_d = 1'b1;
      end
      RUN: if (stop) begin
        state_d = STOPPING;
      end else if (start) begin
        step_d  = step;
        phase_d = '0;
        wpend_d = 1'b1;
      end else if (tick) begin
        rom_en_d   = 1'b1;
        rom_addr_d = phase_q[PHASE_W-1 -: AW];
        iss_w_d    = wpend_q;
        phase_d    = sum_w[PHASE_W-1:0];
        wpend_d    = sum_w[PHASE_W];
      end
      STOPPING: if (!rom_en_q && !ret_v_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // State and registered outputs; async reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      step_q         <= '0;
      phase_q        <= '0;
      wpend_q        <= 1'b0;
      rom_en_q       <= 1'b0;
      rom_addr_q     <= '0;
      iss_w_q        <= 1'b0;
      ret_v_q        <= 1'b0;
      ret_w_q        <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      phase_q        <= phase_d;
      wpend_q        <= wpend_d;
      rom_en_q       <= rom_en_d;
      rom_addr_q     <= rom_addr_d;
      iss_w_q        <= iss_w_d;
      ret_v_q        <= ret_v_d;
      ret_w_q        <= ret_w_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      wrap_q         <= wrap_d;
      busy_q         <= busy_d;
    end
  end
  assign rom_en       = rom_en_q;
  assign rom_addr     = rom_addr_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign wrap         = wrap_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_sine_rom_sequencer.sv
// tb_sine_rom_sequencer: directed bench for sine_rom_sequencer with a synchronous ROM model
module tb_sine_rom_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [15:0] step = '0;
  logic rom_en, sample_valid, wrap, busy;
  logic [5:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] sample;
  int checks = 0, failures = 0;
  logic [5:0] aq[$];
  logic [31:0] sq[$];
  logic wq[$];

  sine_rom_sequencer #(.WIDTH(32), .DEPTH(64), .PHASE_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .tick(tick),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample(sample), .sample_valid(sample_valid), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memv(input int i);
    return {8'hA5, 8'(i), 8'(~i), 8'(i * 3 + 1)};
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= memv(int'(rom_addr));

  always @(posedge clk) begin
    #1;
    if (rom_en) aq.push_back(rom_addr);
    if (sample_valid) begin
      sq.push_back(sample);
      wq.push_back(wrap);
    end
  end

  task automatic clear_q();
    aq.delete();
    sq.delete();
    wq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rom_en, rom_addr, sample, sample_valid, wrap, busy} !== '0) begin
      failures++;
      $display("FAIL reset_values got=%h exp=0", {rom_en, rom_addr, sample, sample_valid, wrap, busy});
    end
    rst = 1'b0;
    step = 16'h0400;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rom_en, rom_addr, sample, sample_valid, wrap, busy} !== '0) begin
      failures++;
      $display("FAIL reset_midrun got=%h exp=0", {rom_en, rom_addr, sample, sample_valid, wrap, busy});
    end
    clear_q();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    tick = 1'b0;
    checks++;
    if (aq.size() != 0 || sq.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_after reads=%0d samples=%0d busy=%b exp=0,0,0", aq.size(), sq.size(), busy);
    end
  endtask

  task automatic test_unit_step();
    clear_q();
    step = 16'h0400;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise got=%b exp=1", busy);
    end
    for (int i = 0; i < 65; i++) begin
      tick = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 6'd0) begin
          failures++;
          $display("FAIL lat_issue rom_en=%b addr=%0d exp=1,0", rom_en, rom_addr);
        end
      end
      if (i == 1) begin
        checks++;
        if (sample_valid !== 1'b0) begin
          failures++;
          $display("FAIL lat_early sample_valid=%b exp=0", sample_valid);
        end
      end
      if (i == 2) begin
        checks++;
        if (sample_valid !== 1'b1 || sample !== memv(0) || wrap !== 1'b1) begin
          failures++;
          $display("FAIL lat_first v=%b s=%h w=%b exp=1,%h,1", sample_valid, sample, wrap, memv(0));
        end
      end
    end
    tick = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (aq.size() != 65 || sq.size() != 65) begin
      failures++;
      $display("FAIL unit_counts reads=%0d samples=%0d exp=65,65", aq.size(), sq.size());
    end
    for (int i = 0; i < 65 && i < aq.size() && i < sq.size(); i++) begin
      checks++;
      if (aq[i] !== 6'(i % 64) || sq[i] !== memv(i % 64) || wq[i] !== (i == 0 || i == 64)) begin
        failures++;
        $display("FAIL unit_seq[%0d] addr=%0d s=%h w=%b exp=%0d,%h,%b", i, aq[i], sq[i], wq[i],
                 i % 64, memv(i % 64), (i == 0 || i == 64));
      end
    end
  endtask

  task automatic test_drain();
    int nv = 0, last = -1, low = -1;
    clear_q();
    tick = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (sample_valid) begin
        nv++;
        last = k;
      end
      if (!busy && low < 0) low = k;
    end
    tick = 1'b0;
    checks++;
    if (aq.size() != 2 || sq.size() != 2 || nv != 2) begin
      failures++;
      $display("FAIL drain_counts reads=%0d samples=%0d exp=2,2", aq.size(), sq.size());
    end
    checks++;
    if (last != 1 || low != 2) begin
      failures++;
      $display("FAIL drain_busy last_valid=%0d busy_low=%0d exp=1,2", last, low);
    end
  endtask

  task automatic test_half_step();
    logic [5:0] ea[5] = '{6'd0, 6'd32, 6'd0, 6'd32, 6'd0};
    logic ew[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_q();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL half_idle busy=%b exp=0", busy);
    end
    step = 16'h8000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (aq.size() != 5 || sq.size() != 5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL half_counts reads=%0d samples=%0d busy=%b exp=5,5,0", aq.size(), sq.size(), busy);
    end
    for (int i = 0; i < 5 && i < aq.size() && i < sq.size(); i++) begin
      checks++;
      if (aq[i] !== ea[i] || sq[i] !== memv(int'(ea[i])) || wq[i] !== ew[i]) begin
        failures++;
        $display("FAIL half_seq[%0d] addr=%0d s=%h w=%b exp=%0d,%h,%b", i, aq[i], sq[i], wq[i],
                 ea[i], memv(int'(ea[i])), ew[i]);
      end
    end
  endtask

  task automatic test_zero_step();
    clear_q();
    step = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (aq.size() != 3 || sq.size() != 3) begin
      failures++;
      $display("FAIL zero_counts reads=%0d samples=%0d exp=3,3", aq.size(), sq.size());
    end
    for (int i = 0; i < 3 && i < aq.size() && i < sq.size(); i++) begin
      checks++;
      if (aq[i] !== 6'd0 || sq[i] !== memv(0) || wq[i] !== (i == 0)) begin
        failures++;
        $display("FAIL zero_seq[%0d] addr=%0d w=%b exp=0,%b", i, aq[i], wq[i], (i == 0));
      end
    end
  endtask

  task automatic test_restart();
    logic [5:0] ea[8] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 6'd4, 6'd8};
    logic ew[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    clear_q();
    step = 16'h0400;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick = 1'b1;
    repeat (5) @(negedge clk);
    step = 16'h1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (aq.size() != 8 || sq.size() != 8 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_counts reads=%0d samples=%0d busy=%b exp=8,8,1", aq.size(), sq.size(), busy);
    end
    for (int i = 0; i < 8 && i < aq.size() && i < sq.size(); i++) begin
      checks++;
      if (aq[i] !== ea[i] || sq[i] !== memv(int'(ea[i])) || wq[i] !== ew[i]) begin
        failures++;
        $display("FAIL restart_seq[%0d] addr=%0d s=%h w=%b exp=%0d,%h,%b", i, aq[i], sq[i], wq[i],
                 ea[i], memv(int'(ea[i])), ew[i]);
      end
    end
  endtask

  task automatic test_start_stop();
    clear_q();
    tick = 1'b1;
    @(negedge clk);
    step = 16'h0400;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b1 || rom_en !== 1'b0) begin
      failures++;
      $display("FAIL ss_cycle busy=%b rom_en=%b exp=1,0", busy, rom_en);
    end
    repeat (6) @(negedge clk);
    tick = 1'b0;
    checks++;
    if (aq.size() != 1 || sq.size() != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ss_counts reads=%0d samples=%0d busy=%b exp=1,1,0", aq.size(), sq.size(), busy);
    end
    if (aq.size() == 1 && sq.size() == 1) begin
      checks++;
      if (aq[0] !== 6'd12 || sq[0] !== memv(12) || wq[0] !== 1'b0) begin
        failures++;
        $display("FAIL ss_sample addr=%0d s=%h w=%b exp=12,%h,0", aq[0], sq[0], wq[0], memv(12));
      end
    end
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ss_idle busy=%b exp=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_unit_step();
    test_drain();
    test_half_step();
    test_zero_step();
    test_restart();
    test_start_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
